// File: rtl/multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier with a combinational product P and a registered copy P_q.
// Latency: P is combinational; P_q and out_valid update one clk edge after in_valid is sampled high.
// Backpressure: none; a new product can be accepted on every cycle.
//
// Ports:
//   clk       - rising-edge clock for P_q / out_valid
//   rst       - asynchronous active-high reset, clears P_q and out_valid
//   A, B      - unsigned operands, WIDTH bits each
//   in_valid  - when high at a clk edge, P is captured into P_q
//   P         - combinational product A*B, 2*WIDTH bits
//   P_q       - registered product
//   out_valid - one-cycle strobe, high while P_q holds the product captured on the previous edge
module multiplier #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 in_valid,
    output logic [2*WIDTH-1:0]   P,
    output logic [2*WIDTH-1:0]   P_q,
    output logic                 out_valid
);

    // Carry-save array. Row i holds sum bits w_s[j] of weight 2^(i+j) and
    // carry bits w_c[j] of weight 2^(i+j+1). The lowest sum bit of each row
    // is final, giving P[WIDTH-1:0] directly.
    logic [WIDTH-1:0] w_plo;

    genvar gi, gj;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
            logic [WIDTH-1:0] w_pp;
            logic [WIDTH-1:0] w_s;
            logic [WIDTH-1:0] w_c;

            for (gj = 0; gj < WIDTH; gj++) begin : g_pp
                assign w_pp[gj] = A[gj] & B[gi];
            end

            if (gi == 0) begin : g_first
                assign w_s = w_pp;
                assign w_c = '0;
            end else begin : g_add
                for (gj = 0; gj < WIDTH; gj++) begin : g_cell
                    if (gj == WIDTH - 1) begin : g_ha
                        // Previous row has no sum bit above its MSB, so only two inputs remain.
                        assign w_s[gj] = w_pp[gj] ^ g_row[gi-1].w_c[gj];
                        assign w_c[gj] = w_pp[gj] & g_row[gi-1].w_c[gj];
                    end else begin : g_fa
                        logic w_x;
                        logic w_y;
                        assign w_x     = g_row[gi-1].w_s[gj+1];
                        assign w_y     = g_row[gi-1].w_c[gj];
                        assign w_s[gj] = w_pp[gj] ^ w_x ^ w_y;
                        assign w_c[gj] = (w_pp[gj] & w_x) | (w_pp[gj] & w_y) | (w_x & w_y);
                    end
                end
            end

            assign w_plo[gi] = w_s[0];
        end
    endgenerate

    // Final ripple-carry adder merging the last row's sum and carry vectors
    // into P[2*WIDTH-1:WIDTH].
    logic [WIDTH-2:0] w_fa;
    logic [WIDTH-2:0] w_fb;
    logic             w_ctop;
    logic [WIDTH-2:0] w_fin;
    logic             w_cy;
    logic             w_top;

    assign w_fa   = g_row[WIDTH-1].w_s[WIDTH-1:1];
    assign w_fb   = g_row[WIDTH-1].w_c[WIDTH-2:0];
    assign w_ctop = g_row[WIDTH-1].w_c[WIDTH-1];

    always_comb begin
        w_fin = '0;
        w_cy  = 1'b0;
        for (int k = 0; k < WIDTH - 1; k++) begin
            w_fin[k] = w_fa[k] ^ w_fb[k] ^ w_cy;
            w_cy     = (w_fa[k] & w_fb[k]) | (w_cy & (w_fa[k] ^ w_fb[k]));
        end
        // The product fits in 2*WIDTH bits, so w_ctop and the ripple carry are
        // never both set; XOR is the full sum of the MSB column.
        w_top = w_ctop ^ w_cy;
    end

    assign P = {w_top, w_fin, w_plo};

    // Registered result path.
    logic [2*WIDTH-1:0] r_p_q;
    logic               r_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_q       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_p_q <= P;
            end
        end
    end

    assign P_q       = r_p_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  a2, b2;
    logic        v2;
    logic [3:0]  p2, pq2;
    logic        ov2;
    logic [7:0]  a8, b8;
    logic        v8;
    logic [15:0] p8, pq8;
    logic        ov8;

    int vectors     = 0;
    int miscompares = 0;

    logic [3:0]  sb2[$];
    logic [15:0] sb8[$];
    logic [3:0]  last2;
    logic [15:0] last8;

    multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .A(a2), .B(b2), .in_valid(v2),
        .P(p2), .P_q(pq2), .out_valid(ov2)
    );

    multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(v8),
        .P(p8), .P_q(pq8), .out_valid(ov8)
    );

    // One registered-path cycle on the WIDTH=2 instance: drive at negedge,
    // check one time unit after the following posedge.
    task automatic cycle2(input logic [1:0] a, input logic [1:0] b, input logic v, input string name);
        logic [3:0] e;
        @(negedge clk);
        a2 = a; b2 = b; v2 = v;
        if (v) begin
            e = {2'b00, a} * {2'b00, b};
            sb2.push_back(e);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ov2 !== v) begin
            miscompares++;
            $display("FAIL %s out_valid w2: got %b want %b", name, ov2, v);
        end
        if (v) begin
            if (sb2.size() == 0) begin
                miscompares++;
                $display("FAIL %s scoreboard2 empty", name);
            end else begin
                last2 = sb2.pop_front();
            end
        end
        vectors++;
        if (pq2 !== last2) begin
            miscompares++;
            $display("FAIL %s P_q w2: got %0d want %0d", name, pq2, last2);
        end
    endtask

    task automatic cycle8(input logic [7:0] a, input logic [7:0] b, input logic v, input string name);
        logic [15:0] e;
        @(negedge clk);
        a8 = a; b8 = b; v8 = v;
        e = {8'd0, a} * {8'd0, b};
        if (v) sb8.push_back(e);
        #1;
        vectors++;
        if (p8 !== e) begin
            miscompares++;
            $display("FAIL %s P w8: got %0d want %0d", name, p8, e);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ov8 !== v) begin
            miscompares++;
            $display("FAIL %s out_valid w8: got %b want %b", name, ov8, v);
        end
        if (v) begin
            if (sb8.size() == 0) begin
                miscompares++;
                $display("FAIL %s scoreboard8 empty", name);
            end else begin
                last8 = sb8.pop_front();
            end
        end
        vectors++;
        if (pq8 !== last8) begin
            miscompares++;
            $display("FAIL %s P_q w8: got %0d want %0d", name, pq8, last8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a2 = 2'd3; b2 = 2'd2; v2 = 1'b1;
        a8 = 8'd0; b8 = 8'd0; v8 = 1'b1;
        #3;
        vectors++;
        if (pq2 !== 4'd0 || ov2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w2: got P_q=%0d ov=%b want 0 0", pq2, ov2);
        end
        vectors++;
        if (pq8 !== 16'd0 || ov8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w8: got P_q=%0d ov=%b want 0 0", pq8, ov8);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pq2 !== 4'd0 || ov2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held_edge: got P_q=%0d ov=%b want 0 0", pq2, ov2);
        end
        vectors++;
        if (p2 !== 4'd6) begin
            miscompares++;
            $display("FAIL reset_comb_P: got %0d want 6", p2);
        end
        v2 = 1'b0; v8 = 1'b0;
        last2 = 4'd0; last8 = 16'd0;
    endtask

    task automatic test_comb_sequence();
        int ta[6] = '{1, 2, 1, 1, 3, 2};
        int tb[6] = '{2, 3, 3, 1, 3, 1};
        int tp[6] = '{2, 6, 3, 1, 9, 2};
        for (int i = 0; i < 6; i++) begin
            a2 = 2'(ta[i]); b2 = 2'(tb[i]);
            #10;
            vectors++;
            if (p2 !== 4'(tp[i])) begin
                miscompares++;
                $display("FAIL comb_seq[%0d]: got %0d want %0d", i, p2, tp[i]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a2 = 2'(i); b2 = 2'(j);
                e = 4'(i * j);
                #2;
                vectors++;
                if (p2 !== e) begin
                    miscompares++;
                    $display("FAIL exhaustive %0d*%0d: got %0d want %0d", i, j, p2, e);
                end
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        last2 = 4'd0;
        cycle2(2'd3, 2'd2, 1'b1, "reg_capture");
        vectors++;
        if (pq2 !== 4'd6) begin
            miscompares++;
            $display("FAIL reg_capture_const: got %0d want 6", pq2);
        end
        // A/B change with in_valid low must not disturb P_q.
        cycle2(2'd1, 2'd1, 1'b0, "reg_hold");
        vectors++;
        if (p2 !== 4'd1) begin
            miscompares++;
            $display("FAIL reg_hold_P: got %0d want 1", p2);
        end
    endtask

    task automatic test_reset_mid();
        cycle2(2'd3, 2'd2, 1'b1, "mid_setup");
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (pq2 !== 4'd0 || ov2 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got P_q=%0d ov=%b want 0 0", pq2, ov2);
        end
        #1;
        rst = 1'b0;
        last2 = 4'd0;
        sb2.delete();
        cycle2(2'd2, 2'd3, 1'b1, "first_after_reset");
    endtask

    task automatic test_wide();
        last8 = 16'd0;
        cycle8(8'd255, 8'd255, 1'b1, "wide_max");
        vectors++;
        if (pq8 !== 16'd65025) begin
            miscompares++;
            $display("FAIL wide_max_const: got %0d want 65025", pq8);
        end
        cycle8(8'd200, 8'd3, 1'b1, "wide_200x3");
        vectors++;
        if (pq8 !== 16'd600) begin
            miscompares++;
            $display("FAIL wide_200x3_const: got %0d want 600", pq8);
        end
        cycle8(8'd0, 8'd77, 1'b1, "wide_zero");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            cycle8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 3) != 0), "b2b_w8");
        end
        for (int i = 0; i < 20; i++) begin
            cycle2(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), "b2b_w2");
        end
        @(negedge clk);
        v2 = 1'b0; v8 = 1'b0;
    endtask

    initial begin
        test_reset();
        rst = 1'b0;
        test_comb_sequence();
        test_exhaustive();
        test_registered();
        test_reset_mid();
        test_wide();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
